// File: rtl/data_mem_sync_if.sv
// Request/response bus between the load/store stage and data_mem_sync.
// master = load/store unit, slave = memory.
interface data_mem_sync_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_we;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we
  );
endinterface

// File: rtl/data_mem_sync.sv
// Synchronous single-port word memory with valid/ready requests and a 2-entry response FIFO.
// Optional power-up clear of the array: define DMEM_INIT_CLEAR_EN.
module data_mem_sync #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 65536
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_sync_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [ADDR_W:0]  addr_x_t;
  typedef logic [IDX_W-1:0] idx_t;
  localparam addr_x_t LIMIT = addr_x_t'(DEPTH);

  typedef struct packed {
    logic              we;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  idx_t clear_ptr;
`else
  typedef enum logic {RUN} state_t;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  state_t     state, state_nxt;
  logic       run;
  logic       in_range;
  idx_t       idx;
  logic       push, pop;
  logic [1:0] count;
  rsp_t       head, tail, rsp_new;

  // Full-width compare so addresses beyond DEPTH never alias into the array.
  assign in_range = ({1'b0, bus.req_addr} < LIMIT);
  assign idx      = idx_t'(bus.req_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef DMEM_INIT_CLEAR_EN
      state <= CLEAR;
`else
      state <= RUN;
`endif
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
`ifdef DMEM_INIT_CLEAR_EN
    if (state == CLEAR && clear_ptr == idx_t'(DEPTH - 1)) state_nxt = RUN;
`endif
  end

  always_comb begin
    run = (state == RUN);
  end

`ifdef DMEM_INIT_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                clear_ptr <= '0;
    else if (state == CLEAR)   clear_ptr <= clear_ptr + idx_t'(1);
  end
`endif

  assign pop           = (count != 2'd0) && bus.rsp_ready;
  assign bus.req_ready = rst_n && run && ((count < 2'd2) || pop);
  assign push          = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk) begin
`ifdef DMEM_INIT_CLEAR_EN
    if (state == CLEAR) mem[clear_ptr] <= '0;
    else
`endif
    if (push && bus.req_we && in_range) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (bus.req_be[b]) mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rsp_new.we    = bus.req_we;
    rsp_new.err   = !in_range;
    rsp_new.rdata = (!bus.req_we && in_range) ? mem[idx] : '0;
  end

  // head is always the oldest entry; a push during a pop from a full FIFO lands behind the shifted tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= rsp_new;
          else               tail <= rsp_new;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= rsp_new;
          end else begin
            head <= rsp_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = (count != 2'd0);
  assign bus.rsp_rdata = head.rdata;
  assign bus.rsp_err   = head.err;
  assign bus.rsp_we    = head.we;
endmodule

// File: tb/tb_data_mem_sync.sv
// Bench for data_mem_sync: vector table, backpressure/throughput sequences, random traffic vs reference model.
module tb_data_mem_sync;
`ifdef DMEM_INIT_CLEAR_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 65536;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_sync_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  data_mem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] rdata;
  } rsp_exp_t;

  logic [31:0] ref_mem [int unsigned];
  rsp_exp_t    exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [31:0] rdata, input logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  // Reference: a word array keyed by address, updated byte-wise for enabled lanes.
  function automatic rsp_exp_t model_req(input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [3:0] be);
    rsp_exp_t r;
    logic [31:0] word;
    r.we    = we;
    r.err   = (addr >= 32'(DEPTH));
    r.rdata = '0;
    if (!r.err) begin
      word = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
        ref_mem[addr] = word;
      end else begin
        r.rdata = word;
      end
    end
    return r;
  endfunction

  task automatic drive_idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
  endtask

  // One request with rsp_ready high; the response must be visible one cycle after accept.
  task automatic table_req(input vec_t v, input string tag);
    int waitc = 0;
    @(negedge clk);
    drive_req(v.we, v.addr, v.wdata, v.be);
    bus.rsp_ready = 1'b1;
    #1;
    while (!bus.req_ready && waitc < 20) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    chk({tag, " req_ready"}, bus.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    #1;
    chk({tag, " rsp_valid"}, bus.rsp_valid, 1'b1);
    chk({tag, " rsp_rdata"}, bus.rsp_rdata, v.rdata);
    chk({tag, " rsp_err"},   bus.rsp_err,   v.err);
    chk({tag, " rsp_we"},    bus.rsp_we,    v.we);
  endtask

  task automatic rnd_cycle(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic rr);
    logic acc;
    rsp_exp_t e;
    @(negedge clk);
    if (v) drive_req(we, a, d, be);
    else   drive_idle();
    bus.rsp_ready = rr;
    #1;
    chk("rnd rsp_valid", bus.rsp_valid, exp_q.size() != 0);
    chk("rnd req_ready", bus.req_ready, (exp_q.size() < 2) || rr);
    if (bus.rsp_valid && rr && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rnd rsp_rdata", bus.rsp_rdata, e.rdata);
      chk("rnd rsp_err",   bus.rsp_err,   e.err);
      chk("rnd rsp_we",    bus.rsp_we,    e.we);
    end
    acc = v && bus.req_ready;
    @(posedge clk);
    if (acc) exp_q.push_back(model_req(we, a, d, be));
  endtask

  task automatic release_reset(output int zeros);
    zeros = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      #1;
      if (bus.req_ready) break;
      zeros++;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t        vecs[$];
    logic [31:0] pool[20];
    logic [31:0] tp_exp[8];
    int          zeros;
    int          drain;

    drive_idle();
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset req_ready", bus.req_ready, 1'b0);
    chk("reset rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset rsp_err",   bus.rsp_err,   1'b0);
    chk("reset rsp_we",    bus.rsp_we,    1'b0);

    release_reset(zeros);
`ifdef DMEM_INIT_CLEAR_EN
    chk("clear cycles", zeros, 16);
    table_req(mk(1'b1, 32'h5, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0), "clr wr5");
    table_req(mk(1'b0, 32'h5, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0), "clr rd5a");
    @(negedge clk);
    rst_n = 1'b0;
    release_reset(zeros);
    chk("clear cycles 2", zeros, 16);
    table_req(mk(1'b0, 32'h5, 32'h0, 4'h0, 32'h0, 1'b0), "clr rd5b");
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("clear mid req_ready", bus.req_ready, 1'b0);
    rst_n = 1'b0;
    release_reset(zeros);
    chk("clear restart cycles", zeros, 16);
`else
    chk("first cycle req_ready", zeros, 0);

    vecs.push_back(mk(1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b1, 32'h10,       32'h11223344, 4'h5, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h10,       32'h0,        4'h0, 32'hDE22BE44, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0,        32'hCAFEF00D, 4'hF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 32'h10000,    32'h00000001, 4'hF, 32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(1'b0, 32'hFFFFFFFF, 32'h0,        4'h0, 32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 32'h10,       32'hFFFFFFFF, 4'h0, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h10,       32'h0,        4'h0, 32'hDE22BE44, 1'b0));
    vecs.push_back(mk(1'b1, 32'hFFFF,     32'h12345678, 4'hF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'hFFFF,     32'h0,        4'h0, 32'h12345678, 1'b0));
    vecs.push_back(mk(1'b0, 32'h10000,    32'h0,        4'h0, 32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 32'h0,        32'h0000AB00, 4'h2, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFEAB0D, 1'b0));
    foreach (vecs[i]) table_req(vecs[i], $sformatf("vec%0d", i));
`endif

    // Backpressure: two responses held, third request stalls until a pop frees a slot.
    table_req(mk(1'b1, 32'h1, 32'h1111AAAA, 4'hF, 32'h0, 1'b0), "bp wr1");
    table_req(mk(1'b1, 32'h2, 32'h2222BBBB, 4'hF, 32'h0, 1'b0), "bp wr2");
    table_req(mk(1'b1, 32'h3, 32'h3333CCCC, 4'hF, 32'h0, 1'b0), "bp wr3");
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 32'h1, 32'h0, 4'h0);
    #1 chk("bp ready0", bus.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b0, 32'h2, 32'h0, 4'h0);
    #1 chk("bp ready1", bus.req_ready, 1'b1);
    chk("bp head1", bus.rsp_rdata, 32'h1111AAAA);
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b0, 32'h3, 32'h0, 4'h0);
    #1 chk("bp full ready", bus.req_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("bp stall%0d ready", k), bus.req_ready, 1'b0);
      chk($sformatf("bp stall%0d valid", k), bus.rsp_valid, 1'b1);
      chk($sformatf("bp stall%0d rdata", k), bus.rsp_rdata, 32'h1111AAAA);
    end
    bus.rsp_ready = 1'b1;
    #1 chk("bp pop ready", bus.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    #1;
    chk("bp rsp2 valid", bus.rsp_valid, 1'b1);
    chk("bp rsp2 rdata", bus.rsp_rdata, 32'h2222BBBB);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("bp rsp3 valid", bus.rsp_valid, 1'b1);
    chk("bp rsp3 rdata", bus.rsp_rdata, 32'h3333CCCC);
    @(posedge clk);
    @(negedge clk);
    #1 chk("bp drained", bus.rsp_valid, 1'b0);

    // Throughput: 8 back-to-back reads, one response per cycle.
    for (int i = 0; i < 8; i++) begin
      case (i % 3)
        0:       tp_exp[i] = 32'h1111AAAA;
        1:       tp_exp[i] = 32'h2222BBBB;
        default: tp_exp[i] = 32'h3333CCCC;
      endcase
    end
    bus.rsp_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) drive_req(1'b0, 32'((i % 3) + 1), 32'h0, 4'h0);
      else       drive_idle();
      #1;
      if (i < 8) chk($sformatf("tp ready%0d", i), bus.req_ready, 1'b1);
      if (i > 0) begin
        chk($sformatf("tp valid%0d", i - 1), bus.rsp_valid, 1'b1);
        chk($sformatf("tp rdata%0d", i - 1), bus.rsp_rdata, tp_exp[i - 1]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    #1 chk("tp drained", bus.rsp_valid, 1'b0);

    // Random traffic over a small address pool including out-of-range edges.
    ref_mem.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) pool[i] = 32'(i);
    pool[16] = 32'(DEPTH - 1);
    pool[17] = 32'(DEPTH);
    pool[18] = 32'(DEPTH + 7);
    pool[19] = 32'hFFFFFFFF;
    for (int i = 0; i < 20; i++) rnd_cycle(1'b1, 1'b1, pool[i], $urandom, 4'hF, 1'b1);
    for (int i = 0; i < 500; i++) begin
      rnd_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                pool[$urandom_range(0, 19)], $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3) != 0);
    end
    drain = 0;
    while (exp_q.size() != 0 && drain < 10) begin
      rnd_cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      drain++;
    end
    chk("rnd queue empty", exp_q.size(), 0);
    @(negedge clk);
    #1 chk("rnd final rsp_valid", bus.rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_sync.md
Name: data_mem_sync

Overview:
- Parametrised, synchronous, single-port word-addressed data memory. Successor to the combinational data memory.
- Requests use a valid/ready handshake with byte-enable writes and range checking.
- Responses return through a 2-entry buffer, so the load/store unit can stall without losing data.
- Sits between the CPU load/store stage and the backing array. Every accepted request produces exactly one response.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 32, width of the request address.
- DEPTH, 65536, number of words; valid addresses are 0..DEPTH-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- req_be  input  DATA_W/8  byte enables; bit i controls bits [8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DATA_W  read data; 0 for writes and out-of-range reads.
- rsp_err  output  1  request address was >= DEPTH.
- rsp_we  output  1  echo of req_we for the request that produced this response.

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset values:
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rsp_we = 0.
  - Response buffer count = 0.
  - req_ready = 0 while rst_n is low.
  - Array contents are not reset, except as defined under Optional Feature.
- Accept: a request is accepted on a rising edge where req_valid && req_ready.
- req_ready = run && ((count - pop) < 2), where:
  - pop = rsp_valid && rsp_ready;
  - the path from rsp_ready to req_ready is combinational by design.
- Latency: a request accepted at edge N has its response visible from the cycle after edge N. This is a 1-cycle latency.
  - Full throughput is 1 request per cycle when rsp_ready is held high.
- Read: the array is read synchronously at the accept edge and the data is written into the response buffer entry.
- Write, in range: at the accept edge, only the enabled bytes of mem[req_addr] are updated. The response carries rdata = 0, err = 0, we = 1.
- Write with req_be = 0: the array is untouched; a normal response is still returned.
- Out of range (req_addr >= DEPTH, full ADDR_W compare, no truncation or aliasing):
  - writes are dropped;
  - reads return rdata = 0;
  - err = 1.
- Response buffer: 2-entry FIFO in strict acceptance order.
  - rsp_valid = (count != 0).
  - rsp_* always reflect the head entry and stay stable while rsp_valid && !rsp_ready.
  - Simultaneous push and pop: count is unchanged, and the new entry queues behind the remaining entry.
  - Full (count = 2, no pop): req_ready = 0.
- Ordering: responses are strictly in order. A read after a write to the same address, in consecutive cycles, returns the new data.
- Reset mid-operation:
  - buffered responses are discarded;
  - a write accepted on the same edge as reset assertion is not guaranteed.
- State machine with the feature disabled: the single state is RUN (run = 1 whenever rst_n is high).

Optional Feature:
- Macro: DMEM_INIT_CLEAR_EN.
- Enabled:
  - States are CLEAR and RUN. Reset enters CLEAR with clear_ptr = 0.
  - In CLEAR, mem[clear_ptr] is written to 0 each cycle and clear_ptr increments. After clear_ptr = DEPTH-1 is written, the FSM moves to RUN.
  - CLEAR lasts exactly DEPTH cycles after reset deassertion; run = 0 and req_ready = 0 during CLEAR.
  - Asserting rst_n low during CLEAR restarts the clear from 0.
- Disabled:
  - No CLEAR state; req_ready can be 1 in the first cycle after reset deassertion.
  - Contents are undefined until written.

Test Plan:
- Full-word write then read: write addr 0x10 data 0xDEADBEEF be 0xF, then read addr 0x10 with rsp_ready = 1 -> responses {we=1, rdata=0, err=0} then {we=0, rdata=0xDEADBEEF, err=0}, each 1 cycle after its accept.
- Partial write: from mem[0x10] = 0xDEADBEEF, write data 0x11223344 be 0x5, then read 0x10 -> rdata 0xDE22BE44.
- Out of range: write addr 65536 data 0x1 -> err=1, and mem[0] is unchanged. Read addr 0xFFFFFFFF -> rdata 0, err 1.
- Backpressure: hold rsp_ready = 0 and issue 3 back-to-back reads of 0x1, 0x2, 0x3 -> req_ready drops after the 2nd accept. Release rsp_ready -> responses in order, with no loss or duplication and rsp_* stable while stalled.
- Throughput: with rsp_ready = 1, issue 8 consecutive reads -> req_ready stays 1, and 8 responses arrive on 8 consecutive cycles.
- DMEM_INIT_CLEAR_EN with DEPTH = 16:
  - After reset, req_ready = 0 for exactly 16 cycles; then reading addr 5 returns 0.
  - Asserting reset at cycle 8 of the clear restarts the full 16-cycle clear.
